// File: rtl/hazard_ctrl.sv
// Hazard and pipeline control for the 5-stage LEGv8 pipeline: load-use stalls with a
// countdown FSM, MEM-resolved branch squashes, and saturating stall/flush counters.
module hazard_ctrl #(
  parameter int unsigned STALL_CYCLES = 1,
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned ZERO_REG     = 31
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             idex_memread,
  input  logic [4:0]       idex_write_reg,
  input  logic [4:0]       ifid_rn,
  input  logic [4:0]       ifid_rm,
  input  logic             ifid_uses_rm,
  input  logic             mem_branch_taken,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_bubble,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             flush_exmem,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic {RUN, STALL} state_t;

  localparam logic [4:0]       ZERO_RD  = ZERO_REG[4:0];
  localparam logic [3:0]       CD_INIT  = 4'(STALL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam bit               MULTI    = (STALL_CYCLES > 1);

  state_t           state_reg;
  logic [3:0]       countdown_reg;
  logic [CNT_W-1:0] stall_cnt_reg;
  logic [CNT_W-1:0] flush_cnt_reg;

  logic rn_match;
  logic rm_match;
  logic hazard;
  logic stalling;

  assign rn_match = (ifid_rn == idex_write_reg);
  assign rm_match = ifid_uses_rm & (ifid_rm == idex_write_reg);
  // XZR as a destination never carries a value, so it can never create a dependency.
  assign hazard   = idex_memread & (idex_write_reg != ZERO_RD) & (rn_match | rm_match);
  assign stalling = (state_reg == STALL) | hazard;

  // Branch squash outranks any stall; reset forces the free-running defaults.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_bubble = 1'b0;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    flush_exmem = 1'b0;
    if (!reset) begin
      if (mem_branch_taken) begin
        flush_ifid  = 1'b1;
        flush_idex  = 1'b1;
        flush_exmem = 1'b1;
      end else if (stalling) begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= RUN;
      countdown_reg <= 4'd0;
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else if (mem_branch_taken) begin
      state_reg     <= RUN;
      countdown_reg <= 4'd0;
      if (flush_cnt_reg != CNT_MAX) flush_cnt_reg <= flush_cnt_reg + CNT_ONE;
    end else if (state_reg == STALL) begin
      if (stall_cnt_reg != CNT_MAX) stall_cnt_reg <= stall_cnt_reg + CNT_ONE;
      if (countdown_reg == 4'd1) begin
        state_reg     <= RUN;
        countdown_reg <= 4'd0;
      end else begin
        countdown_reg <= countdown_reg - 4'd1;
      end
    end else if (hazard) begin
      if (stall_cnt_reg != CNT_MAX) stall_cnt_reg <= stall_cnt_reg + CNT_ONE;
      // The detecting cycle is the first bubble; the FSM covers the remainder.
      if (MULTI) begin
        state_reg     <= STALL;
        countdown_reg <= CD_INIT;
      end
    end
  end

  assign stall_count = stall_cnt_reg;
  assign flush_count = flush_cnt_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: three parameterisations driven in lockstep and
// checked against a bubble-debt reference model, plus table vectors and corner sequences.
module tb_hazard_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       idex_memread;
  logic [4:0] idex_write_reg;
  logic [4:0] ifid_rn;
  logic [4:0] ifid_rm;
  logic       ifid_uses_rm;
  logic       mem_branch_taken;

  logic        pcw [3];
  logic        ifw [3];
  logic        bub [3];
  logic        fi  [3];
  logic        fe  [3];
  logic        fm  [3];
  logic [31:0] sc0, sc1, fc0, fc1;
  logic [3:0]  sc2, fc2;

  always #5 clock = ~clock;

  // Instance 0: single-bubble stalls; 1: three-bubble stalls; 2: 4-bit counters.
  hazard_ctrl #(.STALL_CYCLES(1), .CNT_W(32), .ZERO_REG(31)) dut1 (
    .clock(clock), .reset(reset), .idex_memread(idex_memread), .idex_write_reg(idex_write_reg),
    .ifid_rn(ifid_rn), .ifid_rm(ifid_rm), .ifid_uses_rm(ifid_uses_rm),
    .mem_branch_taken(mem_branch_taken), .pc_write(pcw[0]), .ifid_write(ifw[0]),
    .idex_bubble(bub[0]), .flush_ifid(fi[0]), .flush_idex(fe[0]), .flush_exmem(fm[0]),
    .stall_count(sc0), .flush_count(fc0));

  hazard_ctrl #(.STALL_CYCLES(3), .CNT_W(32), .ZERO_REG(31)) dut3 (
    .clock(clock), .reset(reset), .idex_memread(idex_memread), .idex_write_reg(idex_write_reg),
    .ifid_rn(ifid_rn), .ifid_rm(ifid_rm), .ifid_uses_rm(ifid_uses_rm),
    .mem_branch_taken(mem_branch_taken), .pc_write(pcw[1]), .ifid_write(ifw[1]),
    .idex_bubble(bub[1]), .flush_ifid(fi[1]), .flush_idex(fe[1]), .flush_exmem(fm[1]),
    .stall_count(sc1), .flush_count(fc1));

  hazard_ctrl #(.STALL_CYCLES(1), .CNT_W(4), .ZERO_REG(31)) dut4 (
    .clock(clock), .reset(reset), .idex_memread(idex_memread), .idex_write_reg(idex_write_reg),
    .ifid_rn(ifid_rn), .ifid_rm(ifid_rm), .ifid_uses_rm(ifid_uses_rm),
    .mem_branch_taken(mem_branch_taken), .pc_write(pcw[2]), .ifid_write(ifw[2]),
    .idex_bubble(bub[2]), .flush_ifid(fi[2]), .flush_idex(fe[2]), .flush_exmem(fm[2]),
    .stall_count(sc2), .flush_count(fc2));

  // {pc_write, ifid_write, idex_bubble, flush_ifid, flush_idex, flush_exmem}
  localparam logic [5:0] O_RUN   = 6'b110000;
  localparam logic [5:0] O_STALL = 6'b001000;
  localparam logic [5:0] O_FLUSH = 6'b110111;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: how many bubble cycles are still owed, plus plain integer counters.
  int          bubbles  [3] = '{1, 3, 1};
  longint      cnt_max  [3] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd15};
  int          owed     [3];
  longint      m_stall  [3];
  longint      m_flush  [3];
  bit          m_valid = 1'b0;
  logic [5:0]  last_out [3];

  function automatic logic [5:0] outs(int i);
    return {pcw[i], ifw[i], bub[i], fi[i], fe[i], fm[i]};
  endfunction

  function automatic logic [31:0] scnt(int i);
    return (i == 0) ? sc0 : (i == 1) ? sc1 : {28'd0, sc2};
  endfunction

  function automatic logic [31:0] fcnt(int i);
    return (i == 0) ? fc0 : (i == 1) ? fc1 : {28'd0, fc2};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive, sample mid-cycle against the model, then advance the model.
  task automatic step(input logic r, input logic mr, input logic [4:0] wr, input logic [4:0] rn,
                      input logic [4:0] rm, input logic urm, input logic br);
    bit hz;
    logic [5:0] e;
    reset = r; idex_memread = mr; idex_write_reg = wr;
    ifid_rn = rn; ifid_rm = rm; ifid_uses_rm = urm; mem_branch_taken = br;
    hz = mr && (wr != 5'd31) && ((rn == wr) || (urm && (rm == wr)));
    #4;
    for (int i = 0; i < 3; i++) begin
      if (r)                 e = O_RUN;
      else if (br)           e = O_FLUSH;
      else if (owed[i] > 0 || hz) e = O_STALL;
      else                   e = O_RUN;
      last_out[i] = outs(i);
      chk($sformatf("ctrl[%0d]", i), {26'd0, outs(i)}, {26'd0, e});
      if (m_valid) begin
        chk($sformatf("stall_count[%0d]", i), scnt(i), m_stall[i][31:0]);
        chk($sformatf("flush_count[%0d]", i), fcnt(i), m_flush[i][31:0]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      if (r) begin
        owed[i] = 0; m_stall[i] = 0; m_flush[i] = 0;
      end else if (br) begin
        owed[i] = 0;
        if (m_flush[i] < cnt_max[i]) m_flush[i]++;
      end else if (owed[i] > 0 || hz) begin
        owed[i] = (owed[i] > 0) ? owed[i] - 1 : bubbles[i] - 1;
        if (m_stall[i] < cnt_max[i]) m_stall[i]++;
      end
    end
    if (r) m_valid = 1'b1;
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic       mr;
    logic [4:0] wr;
    logic [4:0] rn;
    logic [4:0] rm;
    logic       urm;
    logic       br;
    logic [5:0] exp_out;
    string      tag;
  } vec_t;

  vec_t vecs [10];

  initial begin
    for (int i = 0; i < 3; i++) begin owed[i] = 0; m_stall[i] = 0; m_flush[i] = 0; end
    vecs[0] = '{1'b1, 5'd5,  5'd5,  5'd0,  1'b0, 1'b0, O_STALL, "load_use_rn"};
    vecs[1] = '{1'b0, 5'd5,  5'd5,  5'd0,  1'b0, 1'b0, O_RUN,   "no_load"};
    vecs[2] = '{1'b1, 5'd31, 5'd31, 5'd31, 1'b1, 1'b0, O_RUN,   "xzr_dest"};
    vecs[3] = '{1'b1, 5'd7,  5'd3,  5'd7,  1'b0, 1'b0, O_RUN,   "rm_unused"};
    vecs[4] = '{1'b1, 5'd7,  5'd3,  5'd7,  1'b1, 1'b0, O_STALL, "rm_used"};
    vecs[5] = '{1'b1, 5'd7,  5'd7,  5'd3,  1'b1, 1'b1, O_FLUSH, "hazard_and_branch"};
    vecs[6] = '{1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b1, O_FLUSH, "branch_only"};
    vecs[7] = '{1'b1, 5'd0,  5'd0,  5'd9,  1'b0, 1'b0, O_STALL, "x0_is_real"};
    vecs[8] = '{1'b1, 5'd12, 5'd11, 5'd13, 1'b1, 1'b0, O_RUN,   "no_match"};
    vecs[9] = '{1'b0, 5'd12, 5'd11, 5'd13, 1'b1, 1'b0, O_RUN,   "idle"};

    @(posedge clock); #1;
    step(1, 1, 5'd5, 5'd5, 5'd0, 0, 0);
    chk("reset_forces_run", {26'd0, last_out[0]}, {26'd0, O_RUN});
    step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    chk("reset_stall_count", sc0, 32'd0);

    // Table vectors, checked explicitly against the single-bubble instance.
    for (int v = 0; v < 10; v++) begin
      step(0, vecs[v].mr, vecs[v].wr, vecs[v].rn, vecs[v].rm, vecs[v].urm, vecs[v].br);
      chk({"vec_", vecs[v].tag}, {26'd0, last_out[0]}, {26'd0, vecs[v].exp_out});
      $display("vec %0d %s out=%b", v, vecs[v].tag, last_out[0]);
    end

    // Three-bubble stall from a single hazard pulse.
    begin
      int nb;
      step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
      nb = 0;
      step(0, 1, 5'd5, 5'd5, 5'd0, 0, 0); nb += int'(last_out[1][3]);
      for (int c = 0; c < 4; c++) begin
        step(0, 0, 5'd5, 5'd5, 5'd0, 0, 0); nb += int'(last_out[1][3]);
      end
      chk("multi_bubble_len", nb, 3);
      chk("multi_stall_count", sc1, 32'd3);
      $display("seq multi-stall bubbles=%0d stall_count=%0d", nb, sc1);
    end

    // Branch in the second bubble cycle aborts the stall.
    step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    step(0, 1, 5'd5, 5'd5, 5'd0, 0, 0);
    step(0, 0, 5'd5, 5'd5, 5'd0, 0, 1);
    chk("abort_flush_out", {26'd0, last_out[1]}, {26'd0, O_FLUSH});
    step(0, 0, 5'd5, 5'd5, 5'd0, 0, 0);
    chk("abort_run_after", {26'd0, last_out[1]}, {26'd0, O_RUN});
    chk("abort_stall_count", sc1, 32'd1);
    chk("abort_flush_count", fc1, 32'd1);
    $display("seq branch-abort stall_count=%0d flush_count=%0d", sc1, fc1);

    // Reset in the middle of a stall.
    step(0, 1, 5'd5, 5'd5, 5'd0, 0, 0);
    step(1, 0, 5'd5, 5'd5, 5'd0, 0, 0);
    step(0, 0, 5'd5, 5'd5, 5'd0, 0, 0);
    chk("midstall_reset_run", {26'd0, last_out[1]}, {26'd0, O_RUN});
    chk("midstall_reset_cnt", sc1, 32'd0);
    $display("seq mid-stall reset out=%b", last_out[1]);

    // Counter saturation on the 4-bit instance.
    for (int c = 0; c < 17; c++) step(0, 1, 5'd4, 5'd4, 5'd0, 0, 0);
    chk("stall_saturate", {28'd0, sc2}, 32'd15);
    for (int c = 0; c < 17; c++) step(0, 0, 5'd4, 5'd4, 5'd0, 0, 1);
    chk("flush_saturate", {28'd0, fc2}, 32'd15);
    $display("seq saturation stall=%0d flush=%0d", sc2, fc2);

    // Randomised traffic against the model, with a narrow register pool to force matches.
    for (int c = 0; c < 600; c++) begin
      logic [4:0] pool [4];
      pool[0] = 5'd31; pool[1] = 5'd5; pool[2] = 5'd7; pool[3] = 5'($urandom_range(0, 31));
      step(($urandom_range(0, 59) == 0), 1'($urandom), pool[$urandom_range(0, 3)],
           pool[$urandom_range(0, 3)], pool[$urandom_range(0, 3)], 1'($urandom),
           ($urandom_range(0, 7) == 0));
    end
    $display("random phase done, stall_count=%0d/%0d/%0d", sc0, sc1, sc2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
